// File: rtl/room_pkg.sv
// rtl/room_pkg.sv - shared constants, enums and wall colour table for the room sequencer
//
// Purpose: grid geometry, raster limits, exit/respawn distances, FSM state and exit
//          direction enums, and the per-room wall colour table (RGB332).
// Ports:   none (package).
package room_pkg;

  localparam int GRID_W       = 3;   // rooms per row; room = row*GRID_W + col
  localparam int GRID_H       = 3;   // rooms per column
  localparam int START_ROOM   = 4;   // room after reset
  localparam int EDGE_MARGIN  = 8;   // pixels from an edge that count as an exit
  localparam int SPAWN_INSET  = 16;  // respawn distance from the entry edge
  localparam int BLANK_FRAMES = 2;   // whole frames blanked during a swap (>=1)

  localparam logic [9:0] H_LAST = 10'd639;
  localparam logic [8:0] V_LAST = 9'd479;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_N,
    DIR_S,
    DIR_W,
    DIR_E
  } exit_dir_t;

  typedef enum logic [1:0] {
    ST_PLAY,
    ST_ARM,
    ST_BLANK,
    ST_SPAWN
  } state_t;

  localparam logic [7:0] ROOM_WALL [0:8] = '{
    8'hE0, 8'hFC, 8'h1F,
    8'hE3, 8'b00011100, 8'h03,
    8'hFF, 8'h92, 8'h6D
  };

endpackage

// File: rtl/frame_tick.sv
// rtl/frame_tick.sv - registered one-cycle pulse after the last pixel of a frame
//
// Purpose: turns the raster position into a frame boundary strobe.
// Ports:   i_clk       pixel clock
//          i_rst       synchronous active-high reset
//          i_x         raster X (0..639)
//          i_y         raster Y (0..479)
//          o_frame_end high for one cycle, the cycle after raster (639,479)
module frame_tick
  import room_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  output logic       o_frame_end
);

  logic r_frame_end;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_end <= 1'b0;
    end else begin
      r_frame_end <= (i_x == H_LAST) && (i_y == V_LAST);
    end
  end

  assign o_frame_end = r_frame_end;

endmodule

// File: rtl/room_sequencer.sv
// rtl/room_sequencer.sv - swaps the active maze room on screen-edge exits, behind a blanking interval
//
// Purpose: watches the player, detects edge exits toward an existing neighbour, swaps the room
//          at a frame boundary, blanks the map for BLANK_FRAMES frames, then offers a respawn
//          position on the opposite edge until player logic acknowledges it.
// Ports:   clk_vga, rst            pixel clock, synchronous active-high reset
//          CurrentX, CurrentY      raster position
//          player_x, player_y      player position
//          spawn_ack               player logic has loaded the spawn position
//          room_sel, wall          active room index and its wall colour
//          map_blank               map layer forced black
//          spawn_valid, spawn_x/y  respawn offer, held until spawn_ack
module room_sequencer
  import room_pkg::*;
(
  input  logic       clk_vga,
  input  logic       rst,
  input  logic [9:0] CurrentX,
  input  logic [8:0] CurrentY,
  input  logic [9:0] player_x,
  input  logic [8:0] player_y,
  input  logic       spawn_ack,
  output logic [3:0] room_sel,
  output logic [7:0] wall,
  output logic       map_blank,
  output logic       spawn_valid,
  output logic [9:0] spawn_x,
  output logic [8:0] spawn_y
);

  localparam logic [9:0] L_X_LO      = 10'(EDGE_MARGIN);
  localparam logic [9:0] L_X_HI      = H_LAST - 10'(EDGE_MARGIN);
  localparam logic [8:0] L_Y_LO      = 9'(EDGE_MARGIN);
  localparam logic [8:0] L_Y_HI      = V_LAST - 9'(EDGE_MARGIN);
  localparam logic [9:0] L_SPX_W     = H_LAST - 10'(SPAWN_INSET);
  localparam logic [9:0] L_SPX_E     = 10'(SPAWN_INSET);
  localparam logic [8:0] L_SPY_N     = V_LAST - 9'(SPAWN_INSET);
  localparam logic [8:0] L_SPY_S     = 9'(SPAWN_INSET);
  localparam logic [1:0] L_START_ROW = 2'(START_ROOM / GRID_W);
  localparam logic [1:0] L_START_COL = 2'(START_ROOM % GRID_W);
  localparam logic [1:0] L_LAST_ROW  = 2'(GRID_H - 1);
  localparam logic [1:0] L_LAST_COL  = 2'(GRID_W - 1);
  localparam logic [1:0] L_BLANK_END = 2'(BLANK_FRAMES - 1);

  logic       w_frame_end;

  state_t     r_state, w_state;
  logic [3:0] r_room, w_room, r_tgt_room, w_tgt_room;
  logic [1:0] r_row, w_row, r_tgt_row, w_tgt_row;
  logic [1:0] r_col, w_col, r_tgt_col, w_tgt_col;
  logic [7:0] r_wall, w_wall;
  logic       r_blank, w_blank;
  logic       r_spawn_valid, w_spawn_valid;
  logic [9:0] r_spawn_x, w_spawn_x, r_px, w_px;
  logic [8:0] r_spawn_y, w_spawn_y, r_py, w_py;
  exit_dir_t  r_dir, w_dir;
  logic [1:0] r_blank_cnt, w_blank_cnt;

  exit_dir_t  w_exit_dir;
  logic       w_exit_ok;
  logic [3:0] w_exit_room;
  logic [1:0] w_exit_row, w_exit_col;

  frame_tick u_frame_tick (
    .i_clk       (clk_vga),
    .i_rst       (rst),
    .i_x         (CurrentX),
    .i_y         (CurrentY),
    .o_frame_end (w_frame_end)
  );

  // Edge exit with N>S>W>E priority. A corner resolves to one direction first;
  // if that direction has no neighbour the exit is dropped rather than retried.
  always_comb begin
    w_exit_dir = DIR_NONE;
    if (player_y < L_Y_LO)       w_exit_dir = DIR_N;
    else if (player_y > L_Y_HI)  w_exit_dir = DIR_S;
    else if (player_x < L_X_LO)  w_exit_dir = DIR_W;
    else if (player_x > L_X_HI)  w_exit_dir = DIR_E;

    w_exit_ok   = 1'b0;
    w_exit_room = r_room;
    w_exit_row  = r_row;
    w_exit_col  = r_col;
    case (w_exit_dir)
      DIR_N: begin
        w_exit_ok   = (r_row != 2'd0);
        w_exit_room = r_room - 4'(GRID_W);
        w_exit_row  = r_row - 2'd1;
      end
      DIR_S: begin
        w_exit_ok   = (r_row != L_LAST_ROW);
        w_exit_room = r_room + 4'(GRID_W);
        w_exit_row  = r_row + 2'd1;
      end
      DIR_W: begin
        w_exit_ok   = (r_col != 2'd0);
        w_exit_room = r_room - 4'd1;
        w_exit_col  = r_col - 2'd1;
      end
      DIR_E: begin
        w_exit_ok   = (r_col != L_LAST_COL);
        w_exit_room = r_room + 4'd1;
        w_exit_col  = r_col + 2'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state       = r_state;
    w_room        = r_room;
    w_row         = r_row;
    w_col         = r_col;
    w_wall        = r_wall;
    w_blank       = r_blank;
    w_spawn_valid = r_spawn_valid;
    w_spawn_x     = r_spawn_x;
    w_spawn_y     = r_spawn_y;
    w_dir         = r_dir;
    w_tgt_room    = r_tgt_room;
    w_tgt_row     = r_tgt_row;
    w_tgt_col     = r_tgt_col;
    w_px          = r_px;
    w_py          = r_py;
    w_blank_cnt   = r_blank_cnt;

    case (r_state)
      ST_PLAY: begin
        if (w_exit_ok) begin
          w_state    = ST_ARM;
          w_dir      = w_exit_dir;
          w_tgt_room = w_exit_room;
          w_tgt_row  = w_exit_row;
          w_tgt_col  = w_exit_col;
          // Respawn uses the position at exit time, not whatever the player does later.
          w_px       = player_x;
          w_py       = player_y;
        end
      end
      ST_ARM: begin
        // Swap only on a frame boundary so a room never changes mid-scan.
        if (w_frame_end) begin
          w_state     = ST_BLANK;
          w_blank     = 1'b1;
          w_room      = r_tgt_room;
          w_row       = r_tgt_row;
          w_col       = r_tgt_col;
          w_wall      = ROOM_WALL[r_tgt_room];
          w_blank_cnt = 2'd0;
        end
      end
      ST_BLANK: begin
        if (w_frame_end) begin
          if (r_blank_cnt == L_BLANK_END) begin
            w_state       = ST_SPAWN;
            w_blank       = 1'b0;
            w_spawn_valid = 1'b1;
            case (r_dir)
              DIR_N:   begin w_spawn_x = r_px;    w_spawn_y = L_SPY_N; end
              DIR_S:   begin w_spawn_x = r_px;    w_spawn_y = L_SPY_S; end
              DIR_W:   begin w_spawn_x = L_SPX_W; w_spawn_y = r_py;    end
              default: begin w_spawn_x = L_SPX_E; w_spawn_y = r_py;    end
            endcase
          end else begin
            w_blank_cnt = r_blank_cnt + 2'd1;
          end
        end
      end
      ST_SPAWN: begin
        if (spawn_ack) begin
          w_state       = ST_PLAY;
          w_spawn_valid = 1'b0;
        end
      end
      default: w_state = ST_PLAY;
    endcase
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_state       <= ST_PLAY;
      r_room        <= 4'(START_ROOM);
      r_row         <= L_START_ROW;
      r_col         <= L_START_COL;
      r_wall        <= ROOM_WALL[START_ROOM];
      r_blank       <= 1'b0;
      r_spawn_valid <= 1'b0;
      r_spawn_x     <= 10'd0;
      r_spawn_y     <= 9'd0;
      r_dir         <= DIR_NONE;
      r_tgt_room    <= 4'(START_ROOM);
      r_tgt_row     <= L_START_ROW;
      r_tgt_col     <= L_START_COL;
      r_px          <= 10'd0;
      r_py          <= 9'd0;
      r_blank_cnt   <= 2'd0;
    end else begin
      r_state       <= w_state;
      r_room        <= w_room;
      r_row         <= w_row;
      r_col         <= w_col;
      r_wall        <= w_wall;
      r_blank       <= w_blank;
      r_spawn_valid <= w_spawn_valid;
      r_spawn_x     <= w_spawn_x;
      r_spawn_y     <= w_spawn_y;
      r_dir         <= w_dir;
      r_tgt_room    <= w_tgt_room;
      r_tgt_row     <= w_tgt_row;
      r_tgt_col     <= w_tgt_col;
      r_px          <= w_px;
      r_py          <= w_py;
      r_blank_cnt   <= w_blank_cnt;
    end
  end

  assign room_sel    = r_room;
  assign wall        = r_wall;
  assign map_blank   = r_blank;
  assign spawn_valid = r_spawn_valid;
  assign spawn_x     = r_spawn_x;
  assign spawn_y     = r_spawn_y;

endmodule

// File: tb/tb_room_sequencer.sv
// tb/tb_room_sequencer.sv - scoreboard bench for room_sequencer
module tb_room_sequencer;

  logic       clk_vga = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] CurrentX = 10'd0;
  logic [8:0] CurrentY = 9'd0;
  logic [9:0] player_x = 10'd320;
  logic [8:0] player_y = 9'd240;
  logic       spawn_ack = 1'b0;
  logic [3:0] room_sel;
  logic [7:0] wall;
  logic       map_blank;
  logic       spawn_valid;
  logic [9:0] spawn_x;
  logic [8:0] spawn_y;

  always #5 clk_vga = ~clk_vga;

  room_sequencer dut (
    .clk_vga     (clk_vga),
    .rst         (rst),
    .CurrentX    (CurrentX),
    .CurrentY    (CurrentY),
    .player_x    (player_x),
    .player_y    (player_y),
    .spawn_ack   (spawn_ack),
    .room_sel    (room_sel),
    .wall        (wall),
    .map_blank   (map_blank),
    .spawn_valid (spawn_valid),
    .spawn_x     (spawn_x),
    .spawn_y     (spawn_y)
  );

  localparam logic [7:0] W0 = 8'hE0;
  localparam logic [7:0] W1 = 8'hFC;
  localparam logic [7:0] W2 = 8'h1F;
  localparam logic [7:0] W3 = 8'hE3;
  localparam logic [7:0] W4 = 8'b00011100;

  typedef struct packed {
    logic [3:0] room;
    logic [7:0] wall;
    logic       blank;
    logic       sv;
    logic [9:0] sx;
    logic [8:0] sy;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    chk_req = 0;
  int    chk_done = 0;
  bit    mon_en = 1'b0;
  obs_t  cur, prev, e;
  string nm;

  function automatic obs_t mk(input logic [3:0] r, input logic [7:0] w, input logic b,
                              input logic v, input logic [9:0] x, input logic [8:0] y);
    obs_t o;
    o.room = r; o.wall = w; o.blank = b; o.sv = v; o.sx = x; o.sy = y;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("room=%0d wall=%02h blank=%0b valid=%0b sx=%0d sy=%0d",
                     o.room, o.wall, o.blank, o.sv, o.sx, o.sy);
  endfunction

  // Monitor: one expectation per visible output change or per explicit check request.
  always @(negedge clk_vga) begin
    cur = {room_sel, wall, map_blank, spawn_valid, spawn_x, spawn_y};
    if (mon_en && (cur != prev || chk_done != chk_req)) begin
      chk_done = chk_req;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: got %s, required no change", fmt(cur));
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (cur !== e) begin
          n_fail++;
          $display("FAIL %s: got %s, required %s", nm, fmt(cur), fmt(e));
        end
      end
    end
    prev = cur;
  end

  task automatic push(input string n, input obs_t o);
    exp_q.push_back(o);
    name_q.push_back(n);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_vga);
    #1;
  endtask

  // Raster hits (639,479) for one cycle; frame_end follows, the FSM acts one cycle later.
  task automatic frame(input bit chk);
    CurrentX = 10'd639; CurrentY = 9'd479;
    tick(1);
    CurrentX = 10'd0;   CurrentY = 9'd0;
    tick(1);
    if (chk) chk_req++;
    tick(2);
  endtask

  task automatic exit_arm(input logic [9:0] x, input logic [8:0] y);
    player_x = x; player_y = y;
    tick(2);
    player_x = 10'd320; player_y = 9'd240;
  endtask

  task automatic do_ack();
    spawn_ack = 1'b1;
    tick(1);
    chk_req++;
    spawn_ack = 1'b0;
    tick(2);
  endtask

  task automatic drain(input string n);
    for (int i = 0; i < 20 && (exp_q.size() != 0 || chk_done != chk_req); i++) tick(1);
    n_tests++;
    if (exp_q.size() != 0 || chk_done != chk_req) begin
      n_fail++;
      $display("FAIL drain_%s: %0d expectations left, required 0", n, exp_q.size());
      exp_q.delete();
      name_q.delete();
      chk_done = chk_req;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    // Reset and idle raster
    tick(3);
    rst = 1'b0;
    tick(1);
    push("reset", mk(4'd4, W4, 0, 0, 10'd0, 9'd0));
    mon_en = 1'b1;
    chk_req++;
    tick(2);
    frame(0);
    push("idle_2_frames", mk(4'd4, W4, 0, 0, 10'd0, 9'd0));
    frame(1);
    drain("reset");

    // West exit 4 -> 3, ack withheld for 3 frames
    exit_arm(10'd3, 9'd200);
    push("w_arm_no_swap", mk(4'd4, W4, 0, 0, 10'd0, 9'd0));
    chk_req++;
    tick(2);
    push("w_swap", mk(4'd3, W3, 1, 0, 10'd0, 9'd0));
    frame(1);
    push("w_blank_hold", mk(4'd3, W3, 1, 0, 10'd0, 9'd0));
    frame(1);
    push("w_spawn", mk(4'd3, W3, 0, 1, 10'd623, 9'd200));
    frame(1);
    for (int i = 0; i < 3; i++) begin
      push("w_spawn_wait", mk(4'd3, W3, 0, 1, 10'd623, 9'd200));
      frame(1);
    end
    push("w_ack", mk(4'd3, W3, 0, 0, 10'd623, 9'd200));
    do_ack();
    drain("west");

    // North exit 3 -> 0
    exit_arm(10'd100, 9'd2);
    push("n_swap", mk(4'd0, W0, 1, 0, 10'd623, 9'd200));
    frame(1);
    frame(0);
    push("n_spawn", mk(4'd0, W0, 0, 1, 10'd100, 9'd463));
    frame(1);
    push("n_ack", mk(4'd0, W0, 0, 0, 10'd100, 9'd463));
    do_ack();
    drain("north");

    // Room 0 north edge has no neighbour; stray ack in PLAY is ignored
    player_x = 10'd300; player_y = 9'd2;
    spawn_ack = 1'b1;
    tick(4);
    frame(0);
    push("no_neighbour", mk(4'd0, W0, 0, 0, 10'd100, 9'd463));
    chk_req++;
    tick(2);
    player_x = 10'd320; player_y = 9'd240;
    spawn_ack = 1'b0;
    tick(2);
    drain("boundary");

    // South exit 0 -> 3, reset mid-blank
    exit_arm(10'd200, 9'd475);
    push("s_swap", mk(4'd3, W3, 1, 0, 10'd100, 9'd463));
    frame(1);
    push("rst_mid_blank", mk(4'd4, W4, 0, 0, 10'd0, 9'd0));
    rst = 1'b1;
    tick(1);
    chk_req++;
    rst = 1'b0;
    tick(2);
    frame(0);
    frame(0);
    push("after_rst_play", mk(4'd4, W4, 0, 0, 10'd0, 9'd0));
    chk_req++;
    tick(2);
    drain("reset_mid");

    // Corner in room 4: north beats west -> room 1
    exit_arm(10'd2, 9'd2);
    push("corner_swap", mk(4'd1, W1, 1, 0, 10'd0, 9'd0));
    frame(1);
    frame(0);
    push("corner_spawn", mk(4'd1, W1, 0, 1, 10'd2, 9'd463));
    frame(1);
    push("corner_ack", mk(4'd1, W1, 0, 0, 10'd2, 9'd463));
    do_ack();
    drain("corner");

    // East exit 1 -> 2
    exit_arm(10'd635, 9'd100);
    push("e_swap", mk(4'd2, W2, 1, 0, 10'd2, 9'd463));
    frame(1);
    frame(0);
    push("e_spawn", mk(4'd2, W2, 0, 1, 10'd16, 9'd100));
    frame(1);
    push("e_ack", mk(4'd2, W2, 0, 0, 10'd16, 9'd100));
    do_ack();
    drain("east");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
